// File: rtl/sram_arb_pkg.sv
// Shared types for the inst/data sram-like arbiter: owner tags and the request bundle.
package sram_arb_pkg;

    typedef logic owner_t;

    localparam owner_t OWNER_INST = 1'b0;
    localparam owner_t OWNER_DATA = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// In-order ownership FIFO: one owner tag per outstanding transaction, popped on data_ok.
module sram_arb_tag_fifo
    import sram_arb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  owner_t push_tag,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_t head
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Depth-1:0] tag_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == DepthCnt);
    assign empty   = (count_q == '0);
    assign head    = tag_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                tag_q[wr_ptr_q] <= push_tag;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like arbiter (inst/data) with address-phase lock and in-order data_ok steering.
// Define SRAM_ARB_RR_EN for round-robin priority; default is fixed data-over-inst.
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_sram_req,
    output logic        mem_sram_wr,
    output logic [1:0]  mem_sram_size,
    output logic [3:0]  mem_sram_wstrb,
    output logic [31:0] mem_sram_addr,
    output logic [31:0] mem_sram_wdata,
    input  logic        mem_sram_addr_ok,
    input  logic        mem_sram_data_ok,
    input  logic [31:0] mem_sram_rdata
);

    logic      run;
    logic      full, empty;
    owner_t    head;
    logic      lock_q, lock_d;
    owner_t    lock_owner_q, lock_owner_d;
    logic      lock_owner_req;
    logic      gnt_valid;
    owner_t    gnt_owner;
    owner_t    prio;
    logic      accept, pop;
    sram_req_t inst_bundle, data_bundle, mem_bundle;

    // Outputs are forced low for as long as reset is asserted.
    assign run = ~reset;

    assign lock_owner_req = (lock_owner_q == OWNER_DATA) ? data_sram_req : inst_sram_req;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_owner = OWNER_DATA;
        if (!full) begin
            if (lock_q) begin
                gnt_owner = lock_owner_q;
                gnt_valid = lock_owner_req;
            end else if (inst_sram_req && data_sram_req) begin
                gnt_valid = 1'b1;
                gnt_owner = prio;
            end else if (data_sram_req) begin
                gnt_valid = 1'b1;
                gnt_owner = OWNER_DATA;
            end else if (inst_sram_req) begin
                gnt_valid = 1'b1;
                gnt_owner = OWNER_INST;
            end
        end
    end

    assign mem_sram_req = run & gnt_valid;
    assign accept       = mem_sram_req & mem_sram_addr_ok;
    assign pop          = run & mem_sram_data_ok & ~empty;

    // Lock survives a full-FIFO stall; it only drops on acceptance or if the owner withdraws.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (mem_sram_req) begin
            lock_d       = 1'b1;
            lock_owner_d = gnt_owner;
        end else if (lock_q && !lock_owner_req) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INST;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Holds the master preferred on the next contended cycle.
    owner_t prio_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= OWNER_DATA;
        end else if (accept) begin
            prio_q <= ~gnt_owner;
        end
    end

    assign prio = prio_q;
`else
    assign prio = OWNER_DATA;
`endif

    sram_arb_tag_fifo #(
        .Depth(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_tag(gnt_owner),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    assign inst_bundle = '{wr: inst_sram_wr, size: inst_sram_size, wstrb: inst_sram_wstrb,
                           addr: inst_sram_addr, wdata: inst_sram_wdata};
    assign data_bundle = '{wr: data_sram_wr, size: data_sram_size, wstrb: data_sram_wstrb,
                           addr: data_sram_addr, wdata: data_sram_wdata};

    assign mem_bundle = !mem_sram_req ? '0 :
                        (gnt_owner == OWNER_DATA) ? data_bundle : inst_bundle;

    assign mem_sram_wr    = mem_bundle.wr;
    assign mem_sram_size  = mem_bundle.size;
    assign mem_sram_wstrb = mem_bundle.wstrb;
    assign mem_sram_addr  = mem_bundle.addr;
    assign mem_sram_wdata = mem_bundle.wdata;

    assign inst_sram_addr_ok = accept & (gnt_owner == OWNER_INST);
    assign data_sram_addr_ok = accept & (gnt_owner == OWNER_DATA);
    assign inst_sram_data_ok = pop & (head == OWNER_INST);
    assign data_sram_data_ok = pop & (head == OWNER_DATA);
    assign inst_sram_rdata   = run ? mem_sram_rdata : '0;
    assign data_sram_rdata   = run ? mem_sram_rdata : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter (MAX_OUTSTANDING = 4).
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_sram_req, mem_sram_wr;
    logic [1:0]  mem_sram_size;
    logic [3:0]  mem_sram_wstrb;
    logic [31:0] mem_sram_addr, mem_sram_wdata;
    logic        mem_sram_addr_ok, mem_sram_data_ok;
    logic [31:0] mem_sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_wr     (inst_sram_wr),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_wstrb  (inst_sram_wstrb),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata),
        .data_sram_req    (data_sram_req),
        .data_sram_wr     (data_sram_wr),
        .data_sram_size   (data_sram_size),
        .data_sram_wstrb  (data_sram_wstrb),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .mem_sram_req     (mem_sram_req),
        .mem_sram_wr      (mem_sram_wr),
        .mem_sram_size    (mem_sram_size),
        .mem_sram_wstrb   (mem_sram_wstrb),
        .mem_sram_addr    (mem_sram_addr),
        .mem_sram_wdata   (mem_sram_wdata),
        .mem_sram_addr_ok (mem_sram_addr_ok),
        .mem_sram_data_ok (mem_sram_data_ok),
        .mem_sram_rdata   (mem_sram_rdata)
    );

    // Lands 1 time unit after the rising edge; inputs change here, checks follow #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
        inst_sram_addr = '0; inst_sram_wdata = '0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'h0;
        data_sram_addr = '0; data_sram_wdata = '0;
        mem_sram_addr_ok = 0; mem_sram_data_ok = 0; mem_sram_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000;
        mem_sram_addr_ok = 1; mem_sram_data_ok = 1; mem_sram_rdata = 32'hdead_beef;
        #1;
        n_cmp++;
        if ({mem_sram_req, mem_sram_addr, inst_sram_addr_ok, inst_sram_data_ok} !== '0) begin
            n_err++;
            $display("FAIL reset_req: req=%0b addr=%h aok=%0b dok=%0b, required all 0",
                     mem_sram_req, mem_sram_addr, inst_sram_addr_ok, inst_sram_data_ok);
        end
        n_cmp++;
        if ({inst_sram_rdata, data_sram_rdata} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata: inst=%h data=%h, required 0", inst_sram_rdata,
                     data_sram_rdata);
        end
        apply_reset();
    endtask

    task automatic test_data_priority();
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000;
        data_sram_req = 1; data_sram_addr = 32'h1c00_8000; data_sram_wr = 1;
        data_sram_wstrb = 4'hf; data_sram_wdata = 32'hcafe_0001;
        mem_sram_addr_ok = 1;
        #1;
        n_cmp++;
        if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin
            n_err++;
            $display("FAIL prio_aok: data=%0b inst=%0b, required data=1 inst=0",
                     data_sram_addr_ok, inst_sram_addr_ok);
        end
        n_cmp++;
        if ({mem_sram_addr, mem_sram_wr, mem_sram_wstrb, mem_sram_wdata}
            !== {32'h1c00_8000, 1'b1, 4'hf, 32'hcafe_0001}) begin
            n_err++;
            $display("FAIL prio_mux: addr=%h wr=%0b wstrb=%h wdata=%h, required data bundle",
                     mem_sram_addr, mem_sram_wr, mem_sram_wstrb, mem_sram_wdata);
        end
        step();
        data_sram_req = 0; data_sram_wr = 0; data_sram_wstrb = 0; data_sram_wdata = 0;
        #1;
        n_cmp++;
        if (inst_sram_addr_ok !== 1'b1 || mem_sram_addr !== 32'h1c00_0000) begin
            n_err++;
            $display("FAIL prio_next_inst: aok=%0b addr=%h, required 1 / 1c000000",
                     inst_sram_addr_ok, mem_sram_addr);
        end
        step();
        idle_inputs();
        mem_sram_data_ok = 1; mem_sram_rdata = 32'ha1;
        #1;
        n_cmp++;
        if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b10 || data_sram_rdata !== 32'ha1) begin
            n_err++;
            $display("FAIL prio_ret0: d=%0b i=%0b rdata=%h, required d=1 i=0 a1",
                     data_sram_data_ok, inst_sram_data_ok, data_sram_rdata);
        end
        step();
        #1;
        n_cmp++;
        if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b01) begin
            n_err++;
            $display("FAIL prio_ret1: d=%0b i=%0b, required d=0 i=1",
                     data_sram_data_ok, inst_sram_data_ok);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_lock();
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                data_sram_req = 1; data_sram_addr = 32'h1c00_8000;
            end
            #1;
            n_cmp++;
            if (mem_sram_req !== 1'b1 || mem_sram_addr !== 32'h1c00_0000 ||
                data_sram_addr_ok !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin
                n_err++;
                $display("FAIL lock_hold c%0d: req=%0b addr=%h iaok=%0b daok=%0b, required inst held",
                         c, mem_sram_req, mem_sram_addr, inst_sram_addr_ok, data_sram_addr_ok);
            end
            step();
        end
        mem_sram_addr_ok = 1;
        #1;
        n_cmp++;
        if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10 || mem_sram_addr !== 32'h1c00_0000) begin
            n_err++;
            $display("FAIL lock_accept: i=%0b d=%0b addr=%h, required i=1 d=0 1c000000",
                     inst_sram_addr_ok, data_sram_addr_ok, mem_sram_addr);
        end
        step();
        inst_sram_req = 0;
        #1;
        n_cmp++;
        if (data_sram_addr_ok !== 1'b1 || mem_sram_addr !== 32'h1c00_8000) begin
            n_err++;
            $display("FAIL lock_then_data: aok=%0b addr=%h, required 1 / 1c008000",
                     data_sram_addr_ok, mem_sram_addr);
        end
        step();
        idle_inputs();
        mem_sram_data_ok = 1;
        step();
        step();
        mem_sram_data_ok = 0;
    endtask

    task automatic test_steering();
        logic [2:0]  who;
        logic [31:0] vals [3];
        who = 3'b010; // bit i set means issue i is from data
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        mem_sram_addr_ok = 1;
        for (int i = 0; i < 3; i++) begin
            inst_sram_req = ~who[i]; data_sram_req = who[i];
            step();
        end
        idle_inputs();
        mem_sram_data_ok = 1;
        for (int i = 0; i < 3; i++) begin
            mem_sram_rdata = vals[i];
            #1;
            n_cmp++;
            if ({data_sram_data_ok, inst_sram_data_ok} !== {who[i], ~who[i]} ||
                inst_sram_rdata !== vals[i] || data_sram_rdata !== vals[i]) begin
                n_err++;
                $display("FAIL steer%0d: d=%0b i=%0b rdata=%h/%h, required d=%0b i=%0b %h",
                         i, data_sram_data_ok, inst_sram_data_ok, inst_sram_rdata,
                         data_sram_rdata, who[i], ~who[i], vals[i]);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        inst_sram_req = 1; mem_sram_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            inst_sram_addr = 32'h1c00_1000 + 32'(i * 4);
            #1;
            n_cmp++;
            if (inst_sram_addr_ok !== 1'b1) begin
                n_err++;
                $display("FAIL full_fill%0d: aok=%0b, required 1", i, inst_sram_addr_ok);
            end
            step();
        end
        mem_sram_data_ok = 1; mem_sram_rdata = 32'h55;
        #1;
        n_cmp++;
        if ({mem_sram_req, inst_sram_addr_ok, inst_sram_data_ok} !== 3'b001) begin
            n_err++;
            $display("FAIL full_block: req=%0b aok=%0b dok=%0b, required 0 0 1",
                     mem_sram_req, inst_sram_addr_ok, inst_sram_data_ok);
        end
        step();
        mem_sram_data_ok = 0;
        #1;
        n_cmp++;
        if ({mem_sram_req, inst_sram_addr_ok} !== 2'b11) begin
            n_err++;
            $display("FAIL full_regrant: req=%0b aok=%0b, required 1 1",
                     mem_sram_req, inst_sram_addr_ok);
        end
        step();
        idle_inputs();
        mem_sram_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin
                n_err++;
                $display("FAIL full_drain%0d: i=%0b d=%0b, required i=1 d=0",
                         i, inst_sram_data_ok, data_sram_data_ok);
            end
            step();
        end
        #1;
        n_cmp++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
            n_err++;
            $display("FAIL full_empty: i=%0b d=%0b, required 0 0", inst_sram_data_ok,
                     data_sram_data_ok);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        mem_sram_addr_ok = 1;
        data_sram_req = 1;
        step();
        data_sram_req = 0; inst_sram_req = 1;
        step();
        reset = 1;
        data_sram_req = 1; mem_sram_data_ok = 1; mem_sram_rdata = 32'h1234_5678;
        data_sram_addr = 32'h1c00_8000;
        #1;
        n_cmp++;
        if ({mem_sram_req, mem_sram_addr, inst_sram_addr_ok, data_sram_addr_ok,
             inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata} !== '0) begin
            n_err++;
            $display("FAIL midreset_out: req=%0b addr=%h aok=%0b%0b dok=%0b%0b rdata=%h, required 0",
                     mem_sram_req, mem_sram_addr, inst_sram_addr_ok, data_sram_addr_ok,
                     inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
        end
        step();
        idle_inputs();
        reset = 0;
        mem_sram_data_ok = 1; mem_sram_rdata = 32'h77;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
                n_err++;
                $display("FAIL spurious%0d: i=%0b d=%0b, required 0 0", i, inst_sram_data_ok,
                         data_sram_data_ok);
            end
            step();
        end
        mem_sram_data_ok = 0;
        data_sram_req = 1; mem_sram_addr_ok = 1;
        step();
        idle_inputs();
        mem_sram_data_ok = 1;
        #1;
        n_cmp++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin
            n_err++;
            $display("FAIL post_reset_ret: i=%0b d=%0b, required i=0 d=1", inst_sram_data_ok,
                     data_sram_data_ok);
        end
        step();
        idle_inputs();
    endtask

    // Both masters request for 6 accepted cycles; data_ok each cycle keeps the FIFO at depth 1.
    task automatic test_contention();
        logic [5:0] exp_data;
`ifdef SRAM_ARB_RR_EN
        exp_data = 6'b010101; // bit k: data wins cycle k
`else
        exp_data = 6'b111111;
`endif
        apply_reset();
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000;
        data_sram_req = 1; data_sram_addr = 32'h1c00_8000;
        mem_sram_addr_ok = 1; mem_sram_data_ok = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++;
            if ({data_sram_addr_ok, inst_sram_addr_ok} !== {exp_data[k], ~exp_data[k]}) begin
                n_err++;
                $display("FAIL contend%0d: d=%0b i=%0b, required d=%0b i=%0b",
                         k, data_sram_addr_ok, inst_sram_addr_ok, exp_data[k], ~exp_data[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if ({data_sram_data_ok, inst_sram_data_ok} !== {exp_data[k-1], ~exp_data[k-1]}) begin
                    n_err++;
                    $display("FAIL contend_ret%0d: d=%0b i=%0b, required d=%0b i=%0b", k,
                             data_sram_data_ok, inst_sram_data_ok, exp_data[k-1], ~exp_data[k-1]);
                end
            end
            step();
        end
        idle_inputs();
        mem_sram_data_ok = 1;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step();
        test_reset();
        test_data_priority();
        test_lock();
        test_steering();
        test_full();
        test_reset_midflight();
        test_contention();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
